dm_port_arbiter: RTL and testbench
==================================

// Module: dm_port_arbiter
// PURPOSE
//   Shares the single-port data memory between the MEM pipeline stage (cpu port) and an
//   external requester (ext port: loader/DMA/debug). Fixed CPU priority with a starvation
//   guard for ext. Sequences each access over MEM_LAT cycles and stalls the pipeline until
//   the CPU access completes. Sits between MEM stage logic and the DM instance.
// PARAMETERS
//   ADDR_W      32  address width, byte addresses
//   DATA_W      32  data width
//   MEM_LAT     1   cycles from mem_en to mem_rdata valid, legal 1..4
//   STARVE_MAX  4   consecutive CPU grants while ext waits before ext is forced next, 1..15
// PORTS
//   clk         in   1       clock, rising edge
//   reset       in   1       asynchronous reset, active-low
//   cpu_req     in   1       MEM-stage access request (load or store)
//   cpu_we      in   1       1 = store
//   cpu_addr    in   ADDR_W  byte address (ALU result)
//   cpu_wdata   in   DATA_W  store data (after RT forwarding)
//   cpu_pc      in   32      PC of the MEM-stage instruction, passed to DM for write logging
//   cpu_stall   out  1       freeze IF..MEM pipeline registers
//   cpu_done    out  1       one-cycle pulse: cpu access complete, cpu_rdata valid
//   cpu_rdata   out  DATA_W  load data
//   ext_req     in   1       external request
//   ext_we      in   1       1 = write
//   ext_addr    in   ADDR_W  byte address
//   ext_wdata   in   DATA_W  write data
//   ext_gnt     out  1       one-cycle pulse: ext request accepted this cycle
//   ext_done    out  1       one-cycle pulse: ext access complete, ext_rdata valid
//   ext_rdata   out  DATA_W  read data
//   mem_en      out  1       DM access strobe, one cycle per access
//   mem_we      out  1       DM write enable, qualified by mem_en
//   mem_addr    out  ADDR_W  word-aligned: {addr[ADDR_W-1:2],2'b00}
//   mem_wdata   out  DATA_W  DM write data
//   mem_pc      out  32      PC to DM (cpu_pc for cpu accesses, 0 for ext)
//   mem_rdata   in   DATA_W  DM read data, valid MEM_LAT cycles after mem_en
// BEHAVIOUR
//   - Reset (reset=0, async): state IDLE, lat_cnt=0, starve_cnt=0; all outputs 0 except
//     cpu_stall = cpu_req (combinational). Reset mid-access aborts it: no done pulse.
//   - FSM IDLE -> CPU_BUSY | EXT_BUSY -> IDLE. Grant decided only in IDLE.
//   - IDLE grant: ext if ext_req && (!cpu_req || starve_cnt==STARVE_MAX); else cpu if cpu_req.
//     Grant cycle: mem_en=1, mem_we/addr/wdata/pc from winner; ext_gnt=1 if ext wins.
//   - BUSY: lat_cnt counts 1..MEM_LAT; at lat_cnt==MEM_LAT sample mem_rdata into owner's
//     rdata register, pulse owner's done, return to IDLE. One idle bubble between accesses.
//   - rdata outputs hold last value until next completion of the same port; writes update
//     nothing (rdata unchanged), done still pulses.
//   - cpu_stall = cpu_req && !cpu_done (combinational); zero-latency stall assertion.
//   - starve_cnt: +1 (saturating at STARVE_MAX) on each cpu grant while ext_req=1; cleared on
//     ext grant or when ext_req=0 in IDLE.
//   - Requesters hold req and fields stable until done; dropping req mid-access does not
//     abort: access completes, done still pulses. mem_* fields are registered at grant.
//   - cpu_req with cpu_done in same cycle is the completing access, not a new request;
//     MEM stage advances on that edge. addr[1:0] ignored (word access only).
// TESTING
//   1 reset=0 mid CPU_BUSY -> mem_en=0, cpu_done=0, cpu_stall=cpu_req, state IDLE after release.
//   2 MEM_LAT=1, cpu load addr 0x0000_0104, mem_rdata=0xDEAD_BEEF -> mem_en@t0 addr 0x104,
//     cpu_done@t1 cpu_rdata=0xDEADBEEF, cpu_stall 1 at t0, 0 at t1.
//   3 cpu store addr 0x0000_0013 data 0x1234_5678 pc 0x3010 -> mem_addr 0x10, mem_we=1,
//     mem_pc 0x3010, cpu_rdata unchanged.
//   4 cpu_req and ext_req together from IDLE -> cpu wins; ext_gnt only after cpu_done+1.
//   5 STARVE_MAX=4, cpu_req and ext_req held high -> 4 cpu grants, then ext_gnt, then cpu.
//   6 MEM_LAT=3, ext read 0x200 -> ext_done exactly 3 cycles after ext_gnt; cpu_stall stays
//     1 for a cpu_req raised meanwhile until its own cpu_done.

Source files
------------

// File: rtl/dm_port_arbiter_if.sv
// dm_port_arbiter_if
//   Bundles the three sides of the data-memory arbiter into one interface:
//   the MEM-stage cpu port, the external (loader/DMA/debug) port and the
//   single-port data memory.
//   Modports:
//     slave  - seen by the arbiter: requester fields and mem_rdata in,
//              stall/done/grant/rdata and mem_* strobes out.
//     master - seen by whatever drives the requests and models the memory.
interface dm_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // cpu port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [31:0]       cpu_pc;
  logic              cpu_stall;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rdata;
  // ext port
  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic              ext_done;
  logic [DATA_W-1:0] ext_rdata;
  // data memory side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [31:0]       mem_pc;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_pc,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    input  mem_rdata,
    output cpu_stall, cpu_done, cpu_rdata,
    output ext_gnt, ext_done, ext_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_pc
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_pc,
    output ext_req, ext_we, ext_addr, ext_wdata,
    output mem_rdata,
    input  cpu_stall, cpu_done, cpu_rdata,
    input  ext_gnt, ext_done, ext_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_pc
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
//   Shares the single-port data memory between the MEM stage (cpu port) and
//   an external requester (ext port). The cpu has fixed priority; ext is
//   forced through after STARVE_MAX consecutive cpu grants while it waits.
//   Each access is granted in IDLE (mem_en strobed that cycle), then waits
//   MEM_LAT cycles in a BUSY state before the owner's done pulses.
//   Ports:
//     clk    - rising-edge clock
//     reset  - asynchronous reset, active low
//     bus    - dm_port_arbiter_if.slave: cpu port, ext port, memory side
module dm_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  dm_port_arbiter_if.slave    bus
);
  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] CPU_BUSY = 2'b01;
  localparam logic [1:0] EXT_BUSY = 2'b10;
  localparam logic [2:0] LAT_MAX    = 3'(MEM_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  logic [1:0]        state_q, state_d;
  logic [2:0]        lat_q, lat_d;
  logic [3:0]        starve_q, starve_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [31:0]       pc_q, pc_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;

  logic              grant_cpu_s, grant_ext_s, mem_en_s;
  logic              last_s, cpu_done_s, ext_done_s;
  logic              win_we_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_wdata_s;
  logic [31:0]       win_pc_s;

  // Grant decision (IDLE only); gated by reset so nothing strobes while held.
  always_comb begin
    grant_cpu_s = 1'b0;
    grant_ext_s = 1'b0;
    if (reset && (state_q == IDLE)) begin
      if (bus.ext_req && (!bus.cpu_req || (starve_q == STARVE_LIM))) begin
        grant_ext_s = 1'b1;
      end else if (bus.cpu_req) begin
        grant_cpu_s = 1'b1;
      end else begin
        grant_cpu_s = 1'b0;
      end
    end else begin
      grant_ext_s = 1'b0;
    end
  end

  assign mem_en_s   = grant_cpu_s | grant_ext_s;
  assign last_s     = (lat_q == LAT_MAX);
  assign cpu_done_s = reset && (state_q == CPU_BUSY) && last_s;
  assign ext_done_s = reset && (state_q == EXT_BUSY) && last_s;

  // Access fields of the winning requester; addr[1:0] dropped for word access.
  always_comb begin
    win_we_s    = grant_ext_s ? bus.ext_we    : bus.cpu_we;
    win_addr_s  = (grant_ext_s ? bus.ext_addr : bus.cpu_addr) & WORD_MASK;
    win_wdata_s = grant_ext_s ? bus.ext_wdata : bus.cpu_wdata;
    win_pc_s    = grant_ext_s ? 32'h0         : bus.cpu_pc;
  end

  // Next-state: FSM, latency counter, starvation counter, captured fields, rdata.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    pc_d        = pc_q;
    cpu_rdata_d = cpu_rdata_q;
    ext_rdata_d = ext_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_ext_s) begin
          state_d  = EXT_BUSY;
          starve_d = 4'd0;
        end else if (grant_cpu_s) begin
          state_d  = CPU_BUSY;
          // Only cpu wins taken while ext is waiting count toward starvation.
          if (!bus.ext_req) begin
            starve_d = 4'd0;
          end else if (starve_q == STARVE_LIM) begin
            starve_d = STARVE_LIM;
          end else begin
            starve_d = starve_q + 4'd1;
          end
        end else begin
          state_d  = IDLE;
          starve_d = bus.ext_req ? starve_q : 4'd0;
        end
        if (mem_en_s) begin
          lat_d   = 3'd1;
          we_d    = win_we_s;
          addr_d  = win_addr_s;
          wdata_d = win_wdata_s;
          pc_d    = win_pc_s;
        end else begin
          lat_d   = 3'd0;
        end
      end
      CPU_BUSY, EXT_BUSY: begin
        if (last_s) begin
          state_d = IDLE;
          lat_d   = 3'd0;
          // Writes leave the owner's rdata untouched.
          if (!we_q && (state_q == CPU_BUSY)) begin
            cpu_rdata_d = bus.mem_rdata;
          end else if (!we_q) begin
            ext_rdata_d = bus.mem_rdata;
          end else begin
            cpu_rdata_d = cpu_rdata_q;
          end
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        lat_d   = 3'd0;
      end
    endcase
  end

  // State registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      lat_q       <= 3'd0;
      starve_q    <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      pc_q        <= 32'h0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      pc_q        <= pc_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
    end
  end

  // Completion cycle forwards mem_rdata so rdata is valid alongside done.
  assign bus.cpu_rdata = (cpu_done_s && !we_q) ? bus.mem_rdata : cpu_rdata_q;
  assign bus.ext_rdata = (ext_done_s && !we_q) ? bus.mem_rdata : ext_rdata_q;
  assign bus.cpu_done  = cpu_done_s;
  assign bus.ext_done  = ext_done_s;
  assign bus.cpu_stall = bus.cpu_req && !cpu_done_s;
  assign bus.ext_gnt   = grant_ext_s;

  // Memory strobes in the grant cycle, captured fields held afterwards.
  assign bus.mem_en    = mem_en_s;
  assign bus.mem_we    = mem_en_s & win_we_s;
  assign bus.mem_addr  = mem_en_s ? win_addr_s  : addr_q;
  assign bus.mem_wdata = mem_en_s ? win_wdata_s : wdata_q;
  assign bus.mem_pc    = mem_en_s ? win_pc_s    : pc_q;
endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  dm_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if1 ();
  dm_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if3 ();

  dm_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  dm_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_pc;
    logic        ext_req;
    logic        ext_we;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic [31:0] mem_rdata;
    logic        e_stall;
    logic        e_cdone;
    logic [31:0] e_crdata;
    logic        e_gnt;
    logic        e_edone;
    logic [31:0] e_erdata;
    logic        e_men;
    logic        e_mwe;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
    logic [31:0] e_mpc;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(
    input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
    input logic [31:0] cp, input logic er, input logic ew, input logic [31:0] ea,
    input logic [31:0] ed, input logic [31:0] mr,
    input logic st, input logic cdn, input logic [31:0] crd,
    input logic gn, input logic edn, input logic [31:0] erd,
    input logic men, input logic mwe, input logic [31:0] ma,
    input logic [31:0] mwd, input logic [31:0] mp);
    vec_t v;
    v.cpu_req = cr;  v.cpu_we = cw;  v.cpu_addr = ca; v.cpu_wdata = cd; v.cpu_pc = cp;
    v.ext_req = er;  v.ext_we = ew;  v.ext_addr = ea; v.ext_wdata = ed; v.mem_rdata = mr;
    v.e_stall = st;  v.e_cdone = cdn; v.e_crdata = crd;
    v.e_gnt = gn;    v.e_edone = edn; v.e_erdata = erd;
    v.e_men = men;   v.e_mwe = mwe;  v.e_maddr = ma; v.e_mwdata = mwd; v.e_mpc = mp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive1(input vec_t v);
    if1.cpu_req   = v.cpu_req;   if1.cpu_we    = v.cpu_we;
    if1.cpu_addr  = v.cpu_addr;  if1.cpu_wdata = v.cpu_wdata;
    if1.cpu_pc    = v.cpu_pc;    if1.ext_req   = v.ext_req;
    if1.ext_we    = v.ext_we;    if1.ext_addr  = v.ext_addr;
    if1.ext_wdata = v.ext_wdata; if1.mem_rdata = v.mem_rdata;
  endtask

  task automatic idle3();
    if3.cpu_req = 1'b0; if3.cpu_we = 1'b0; if3.cpu_addr = 32'h0; if3.cpu_wdata = 32'h0;
    if3.cpu_pc = 32'h0; if3.ext_req = 1'b0; if3.ext_we = 1'b0; if3.ext_addr = 32'h0;
    if3.ext_wdata = 32'h0; if3.mem_rdata = 32'h0;
  endtask

  initial begin
    logic seq_ext[6];
    int   ng;
    total = 0;
    bad   = 0;

    //           cpu: req we addr  wdata  pc      ext: req we addr  wdata  mem_rdata
    //           exp: stall done rdata  gnt done rdata  men mwe maddr mwdata mpc
    vecs[0]  = mk(0,0,32'h0,32'h0,32'h0,       0,0,32'h0,32'h0,32'h0,
                  0,0,32'h0,        0,0,32'h0,        0,0,32'h0,32'h0,32'h0);
    vecs[1]  = mk(1,0,32'h104,32'h0,32'h1000,  0,0,32'h0,32'h0,32'h0,
                  1,0,32'h0,        0,0,32'h0,        1,0,32'h104,32'h0,32'h1000);
    vecs[2]  = mk(1,0,32'h104,32'h0,32'h1000,  0,0,32'h0,32'h0,32'hDEADBEEF,
                  0,1,32'hDEADBEEF, 0,0,32'h0,        0,0,32'h104,32'h0,32'h1000);
    vecs[3]  = mk(0,0,32'h0,32'h0,32'h0,       0,0,32'h0,32'h0,32'h0,
                  0,0,32'hDEADBEEF, 0,0,32'h0,        0,0,32'h104,32'h0,32'h1000);
    vecs[4]  = mk(1,1,32'h13,32'h12345678,32'h3010, 0,0,32'h0,32'h0,32'hAAAA5555,
                  1,0,32'hDEADBEEF, 0,0,32'h0,        1,1,32'h10,32'h12345678,32'h3010);
    vecs[5]  = mk(1,1,32'h13,32'h12345678,32'h3010, 0,0,32'h0,32'h0,32'hAAAA5555,
                  0,1,32'hDEADBEEF, 0,0,32'h0,        0,0,32'h10,32'h12345678,32'h3010);
    vecs[6]  = mk(0,0,32'h0,32'h0,32'h0,       0,0,32'h0,32'h0,32'h0,
                  0,0,32'hDEADBEEF, 0,0,32'h0,        0,0,32'h10,32'h12345678,32'h3010);
    vecs[7]  = mk(1,0,32'h20,32'h0,32'h1004,   1,0,32'h40,32'h0,32'h11111111,
                  1,0,32'hDEADBEEF, 0,0,32'h0,        1,0,32'h20,32'h0,32'h1004);
    vecs[8]  = mk(1,0,32'h20,32'h0,32'h1004,   1,0,32'h40,32'h0,32'h11111111,
                  0,1,32'h11111111, 0,0,32'h0,        0,0,32'h20,32'h0,32'h1004);
    vecs[9]  = mk(0,0,32'h0,32'h0,32'h0,       1,0,32'h40,32'h0,32'h22222222,
                  0,0,32'h11111111, 1,0,32'h0,        1,0,32'h40,32'h0,32'h0);
    vecs[10] = mk(0,0,32'h0,32'h0,32'h0,       1,0,32'h40,32'h0,32'h22222222,
                  0,0,32'h11111111, 0,1,32'h22222222, 0,0,32'h40,32'h0,32'h0);
    vecs[11] = mk(0,0,32'h0,32'h0,32'h0,       0,0,32'h0,32'h0,32'h0,
                  0,0,32'h11111111, 0,0,32'h22222222, 0,0,32'h40,32'h0,32'h0);
    vecs[12] = mk(0,0,32'h0,32'h0,32'h0,       1,1,32'h47,32'hCAFEF00D,32'h33333333,
                  0,0,32'h11111111, 1,0,32'h22222222, 1,1,32'h44,32'hCAFEF00D,32'h0);
    vecs[13] = mk(0,0,32'h0,32'h0,32'h0,       1,1,32'h47,32'hCAFEF00D,32'h33333333,
                  0,0,32'h11111111, 0,1,32'h22222222, 0,0,32'h44,32'hCAFEF00D,32'h0);
    vecs[14] = mk(0,0,32'h0,32'h0,32'h0,       0,0,32'h0,32'h0,32'h0,
                  0,0,32'h11111111, 0,0,32'h22222222, 0,0,32'h44,32'hCAFEF00D,32'h0);

    // Reset state: outputs 0, stall follows cpu_req.
    reset = 1'b0;
    drive1(vecs[0]);
    idle3();
    if1.cpu_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.cpu_stall", 32'(if1.cpu_stall), 32'd1);
    chk("rst.mem_en",    32'(if1.mem_en),    32'd0);
    chk("rst.cpu_done",  32'(if1.cpu_done),  32'd0);
    chk("rst.ext_gnt",   32'(if1.ext_gnt),   32'd0);
    chk("rst.mem_addr",  if1.mem_addr,       32'h0);
    chk("rst.cpu_rdata", if1.cpu_rdata,      32'h0);
    if1.cpu_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Table-driven vectors on the MEM_LAT=1 instance, one cycle each.
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      drive1(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d.cpu_stall", i), 32'(if1.cpu_stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d.cpu_done", i),  32'(if1.cpu_done),  32'(vecs[i].e_cdone));
      chk($sformatf("v%0d.cpu_rdata", i), if1.cpu_rdata,      vecs[i].e_crdata);
      chk($sformatf("v%0d.ext_gnt", i),   32'(if1.ext_gnt),   32'(vecs[i].e_gnt));
      chk($sformatf("v%0d.ext_done", i),  32'(if1.ext_done),  32'(vecs[i].e_edone));
      chk($sformatf("v%0d.ext_rdata", i), if1.ext_rdata,      vecs[i].e_erdata);
      chk($sformatf("v%0d.mem_en", i),    32'(if1.mem_en),    32'(vecs[i].e_men));
      chk($sformatf("v%0d.mem_we", i),    32'(if1.mem_we),    32'(vecs[i].e_mwe));
      chk($sformatf("v%0d.mem_addr", i),  if1.mem_addr,       vecs[i].e_maddr);
      chk($sformatf("v%0d.mem_wdata", i), if1.mem_wdata,      vecs[i].e_mwdata);
      chk($sformatf("v%0d.mem_pc", i),    if1.mem_pc,         vecs[i].e_mpc);
    end

    // Starvation guard: both held -> C C C C E C.
    @(posedge clk); #1;
    if1.cpu_req = 1'b1; if1.cpu_we = 1'b0; if1.cpu_addr = 32'h80; if1.cpu_pc = 32'h2000;
    if1.ext_req = 1'b1; if1.ext_we = 1'b0; if1.ext_addr = 32'h90;
    if1.mem_rdata = 32'h0BADF00D;
    ng = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (if1.mem_en) begin
        if (ng < 6) seq_ext[ng] = if1.ext_gnt;
        ng++;
      end
      @(posedge clk); #1;
    end
    if1.cpu_req = 1'b0;
    if1.ext_req = 1'b0;
    chk("starve.grants", 32'(ng), 32'd6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("starve.g%0d_is_ext", k), 32'(seq_ext[k]), (k == 4) ? 32'd1 : 32'd0);
    end

    // Reset asserted mid CPU_BUSY aborts the access.
    @(posedge clk); #1;
    if1.cpu_req = 1'b1; if1.cpu_addr = 32'h8; if1.cpu_pc = 32'h2004;
    if1.mem_rdata = 32'h77777777;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("abort.mem_en",    32'(if1.mem_en),    32'd0);
    chk("abort.cpu_done",  32'(if1.cpu_done),  32'd0);
    chk("abort.cpu_stall", 32'(if1.cpu_stall), 32'd1);
    chk("abort.cpu_rdata", if1.cpu_rdata,      32'h0);
    if1.cpu_req = 1'b0;
    #1;
    chk("abort.stall_low", 32'(if1.cpu_stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("abort.idle%0d.mem_en", c),   32'(if1.mem_en),   32'd0);
      chk($sformatf("abort.idle%0d.cpu_done", c), 32'(if1.cpu_done), 32'd0);
    end

    // MEM_LAT=3: ext read 0x200, cpu request raised while ext is busy.
    @(posedge clk); #1;
    if3.ext_req = 1'b1; if3.ext_we = 1'b0; if3.ext_addr = 32'h200;
    if3.mem_rdata = 32'h5A5A0200;
    @(negedge clk);
    chk("lat3.ext_gnt",  32'(if3.ext_gnt), 32'd1);
    chk("lat3.mem_addr", if3.mem_addr,     32'h200);
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        if3.cpu_req = 1'b1; if3.cpu_we = 1'b0; if3.cpu_addr = 32'h300; if3.cpu_pc = 32'h4000;
      end
      if (i == 4) begin
        if3.ext_req = 1'b0;
        if3.mem_rdata = 32'hC0DE0001;
      end
      @(negedge clk);
      chk($sformatf("lat3.t%0d.ext_done", i),  32'(if3.ext_done),  (i == 3) ? 32'd1 : 32'd0);
      chk($sformatf("lat3.t%0d.cpu_done", i),  32'(if3.cpu_done),  (i == 7) ? 32'd1 : 32'd0);
      chk($sformatf("lat3.t%0d.cpu_stall", i), 32'(if3.cpu_stall), (i == 7) ? 32'd0 : 32'd1);
      chk($sformatf("lat3.t%0d.mem_en", i),    32'(if3.mem_en),    (i == 4) ? 32'd1 : 32'd0);
    end
    chk("lat3.ext_rdata", if3.ext_rdata, 32'h5A5A0200);
    chk("lat3.cpu_rdata", if3.cpu_rdata, 32'hC0DE0001);
    @(posedge clk); #1;
    if3.cpu_req = 1'b0;
    @(negedge clk);
    chk("lat3.end_stall", 32'(if3.cpu_stall), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
